// File: rtl/osecpu_loader_pkg.sv
// Shared definitions for the OSECPU program loader: sync byte, FSM states
// and error codes reported on err_code.
package osecpu_loader_pkg;

  localparam logic [7:0] LOADER_SYNC = 8'hA5;

  typedef enum logic [2:0] {
    LSTATE_IDLE,
    LSTATE_CNT_HI,
    LSTATE_CNT_LO,
    LSTATE_DATA,
    LSTATE_CHK,
    LSTATE_DONE,
    LSTATE_ERR
  } lstate_t;

  localparam logic [1:0] LERR_NONE    = 2'd0;
  localparam logic [1:0] LERR_COUNT   = 2'd1;
  localparam logic [1:0] LERR_CSUM    = 2'd2;
  localparam logic [1:0] LERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/osecpu_loader_timeout.sv
// Idle-clock counter for the loader: counts clocks without an accepted byte
// while a frame is in progress and flags expiry on the TIMEOUT-th idle clock.
module LoaderTimeout #(
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  // Combinational expiry lets the FSM enter ERR on the same edge that would
  // complete the TIMEOUT-th idle clock.
  assign expired = enable && !clear && (cnt == W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear || !enable) begin
      cnt <= '0;
    end else if (!expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/osecpu_loader.sv
// Framed byte-stream program loader: assembles big-endian words, writes them
// to memory from BASE_ADDR and releases the CPU after a verified checksum.
module osecpu_loader
  import osecpu_loader_pkg::*;
#(
  parameter logic [15:0]  BASE_ADDR = 16'h0000,
  parameter logic [15:0]  MEM_WORDS = 16'h1000,
  parameter int unsigned  TIMEOUT   = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        cpu_run,
  output logic        busy,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [15:0] words_loaded
);

  lstate_t     state;
  logic [15:0] count;
  logic [23:0] word;
  logic [1:0]  byte_idx;
  logic [7:0]  csum;
  logic        accept;
  logic        expired;
  logic [15:0] count_full;
  logic [15:0] words_next;

  assign accept     = in_valid && in_ready;
  assign count_full = {count[15:8], in_data};
  assign words_next = words_loaded + 16'd1;

  LoaderTimeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .enable  (busy),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= LSTATE_IDLE;
      in_ready     <= 1'b0;
      count        <= '0;
      word         <= '0;
      byte_idx     <= '0;
      csum         <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_we       <= 1'b0;
      cpu_run      <= 1'b0;
      busy         <= 1'b0;
      error        <= 1'b0;
      err_code     <= LERR_NONE;
      words_loaded <= '0;
    end else begin
      in_ready <= 1'b1;
      mem_we   <= 1'b0;
      case (state)
        LSTATE_IDLE, LSTATE_DONE, LSTATE_ERR: begin
          if (accept && in_data == LOADER_SYNC) begin
            state        <= LSTATE_CNT_HI;
            cpu_run      <= 1'b0;
            busy         <= 1'b1;
            error        <= 1'b0;
            err_code     <= LERR_NONE;
            words_loaded <= '0;
            csum         <= '0;
            byte_idx     <= '0;
          end
        end
        LSTATE_CNT_HI: begin
          if (accept) begin
            count[15:8] <= in_data;
            state       <= LSTATE_CNT_LO;
          end else if (expired) begin
            state    <= LSTATE_ERR;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= LERR_TIMEOUT;
          end
        end
        LSTATE_CNT_LO: begin
          if (accept) begin
            count <= count_full;
            if (count_full > MEM_WORDS) begin
              state    <= LSTATE_ERR;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= LERR_COUNT;
            end else if (count_full == 16'd0) begin
              state <= LSTATE_CHK;
            end else begin
              state <= LSTATE_DATA;
            end
          end else if (expired) begin
            state    <= LSTATE_ERR;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= LERR_TIMEOUT;
          end
        end
        LSTATE_DATA: begin
          if (accept) begin
            csum     <= csum ^ in_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_we       <= 1'b1;
              mem_addr     <= BASE_ADDR + words_loaded;
              mem_wdata    <= {word, in_data};
              words_loaded <= words_next;
              if (words_next == count) begin
                state <= LSTATE_CHK;
              end
            end else begin
              word <= {word[15:0], in_data};
            end
          end else if (expired) begin
            state    <= LSTATE_ERR;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= LERR_TIMEOUT;
          end
        end
        LSTATE_CHK: begin
          if (accept) begin
            busy <= 1'b0;
            if (in_data == csum) begin
              state   <= LSTATE_DONE;
              cpu_run <= 1'b1;
            end else begin
              state    <= LSTATE_ERR;
              error    <= 1'b1;
              err_code <= LERR_CSUM;
            end
          end else if (expired) begin
            state    <= LSTATE_ERR;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= LERR_TIMEOUT;
          end
        end
        default: begin
          state <= LSTATE_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
